// File: rtl/nibble_serial_compare_ctrl.sv
// nibble_serial_compare_ctrl: unsigned A vs B magnitude compare through one 4-bit slice, MSB nibble first, early exit.
// Latency: done pulses k cycles after start is accepted, k = position of the first unequal nibble from the MSB (max NIBBLES).
// Backpressure: none; start is ignored while busy, and may be re-issued in the done cycle for back-to-back compares.

// 4-bit magnitude-compare slice with AGB/AEB/ALB outputs.
module nibble_mag_cmp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       agb,
  output logic       aeb,
  output logic       alb
);

  // Purely combinational compare; exactly one output is high.
  always_comb begin
    agb = (a > b);
    aeb = (a == b);
    alb = (a < b);
  end

endmodule

module nibble_serial_compare_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic                 AGB,
  output logic                 AEB,
  output logic                 ALB
);

  localparam int W  = 4 * NIBBLES;
  // Index register needs to hold NIBBLES-1; keep at least one bit for NIBBLES=1.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [IW-1:0] idx;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic          slice_agb;
  logic          slice_aeb;
  logic          slice_alb;
  logic          decisive;

  // Steer the nibble under test into the slice; a compare-and-select loop
  // keeps the selection in range for any NIBBLES, including non powers of two.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  nibble_mag_cmp u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .agb (slice_agb),
    .aeb (slice_aeb),
    .alb (slice_alb)
  );

  // The compare ends on the first unequal nibble, or after the LSB nibble when all matched.
  always_comb begin
    decisive = slice_agb || slice_alb || (idx == '0);
  end

  // Controller FSM: operand capture, nibble walk, and registered busy/done/result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      AGB   <= 1'b0;
      AEB   <= 1'b0;
      ALB   <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE so compares can run back-to-back.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            idx   <= LAST_IDX;
            busy  <= 1'b1;
            state <= COMPARE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        // start is deliberately not looked at here; operands are already latched.
        COMPARE: begin
          if (decisive) begin
            AGB   <= slice_agb;
            AEB   <= slice_aeb;
            ALB   <= slice_alb;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx - 1'b1;
          end
        end

        // Unused encoding: recover quietly to IDLE without touching the result flags.
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
